// File: rtl/exc_arb_if.sv
// Request/response bundle between the memory-stage exception collector and the
// exception arbiter (CP0 update fields, redirect target and flush).
interface exc_arb_if #(
  parameter int unsigned NUM_SRC      = 12,
  parameter int unsigned INT_W        = 8,
  parameter int unsigned FLUSH_STAGES = 4
);
  logic [NUM_SRC-1:0]      exc_req;
  logic [NUM_SRC*5-1:0]    exc_code_in;
  logic [NUM_SRC-1:0]      exc_refill;
  logic [NUM_SRC-1:0]      exc_bad_we;
  logic [NUM_SRC*32-1:0]   exc_badaddr;
  logic [31:0]             epc_in;
  logic                    eret;
  logic [31:0]             eret_target;
  logic                    allow_int;
  logic [INT_W-1:0]        int_pending;
  logic                    sr_bev;
  logic                    sr_exl;
  logic [31:0]             ebase;
  logic                    fetch_ack;

  logic                    cur_exc;
  logic                    flush;
  logic [FLUSH_STAGES-1:0] flush_vec;
  logic                    cp0_wr_exp;
  logic                    clear_exl;
  logic [4:0]              exc_code;
  logic [31:0]             epc;
  logic [31:0]             badvaddr;
  logic                    badvaddr_we;
  logic [31:0]             new_pc;

  modport master (
    output exc_req, exc_code_in, exc_refill, exc_bad_we, exc_badaddr, epc_in,
           eret, eret_target, allow_int, int_pending, sr_bev, sr_exl, ebase, fetch_ack,
    input  cur_exc, flush, flush_vec, cp0_wr_exp, clear_exl, exc_code, epc,
           badvaddr, badvaddr_we, new_pc
  );

  modport slave (
    input  exc_req, exc_code_in, exc_refill, exc_bad_we, exc_badaddr, epc_in,
           eret, eret_target, allow_int, int_pending, sr_bev, sr_exl, ebase, fetch_ack,
    output cur_exc, flush, flush_vec, cp0_wr_exp, clear_exl, exc_code, epc,
           badvaddr, badvaddr_we, new_pc
  );
endinterface

// File: rtl/exc_arbiter.sv
// N-source exception/interrupt/ERET arbiter with flush-hold FSM.
// Optional macro EXC_ARB_PERF_CNT_EN adds the exc_count performance counter.
module exc_arbiter #(
  parameter int unsigned NUM_SRC      = 12,
  parameter int unsigned INT_W        = 8,
  parameter int unsigned FLUSH_STAGES = 4,
  parameter int unsigned MIN_FLUSH    = 1
) (
  input  logic          clk,
  input  logic          reset,
  exc_arb_if.slave      bus
`ifdef EXC_ARB_PERF_CNT_EN
  ,
  output logic [31:0]   exc_count
`endif
);

  localparam int unsigned    CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(15);
  localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_FLUSH);
  localparam logic [31:0]      BEV_BASE = 32'hBFC0_0200;
  localparam logic [31:0]      GEN_OFS  = 32'h0000_0180;

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

  state_t           r_state, w_nxt_state;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic             r_flush, w_nxt_flush;
  logic             r_cp0_wr_exp, w_nxt_cp0_wr_exp;
  logic             r_clear_exl, w_nxt_clear_exl;
  logic [4:0]       r_exc_code, w_nxt_exc_code;
  logic [31:0]      r_epc, w_nxt_epc;
  logic [31:0]      r_badvaddr, w_nxt_badvaddr;
  logic             r_badvaddr_we, w_nxt_badvaddr_we;
  logic [31:0]      r_new_pc, w_nxt_new_pc;

  logic [INT_W-1:0] w_int_pend;
  logic             w_int;
  logic             w_src_hit;
  logic [4:0]       w_src_code;
  logic             w_src_refill;
  logic             w_src_bad_we;
  logic [31:0]      w_src_badaddr;
  logic [31:0]      w_base;
  logic             w_take;

  assign w_int_pend = bus.int_pending;
  assign w_int      = bus.allow_int & (|w_int_pend);
  assign w_base     = bus.sr_bev ? BEV_BASE : bus.ebase;
  assign w_take     = (r_state == ST_IDLE) & (w_int | w_src_hit | bus.eret);

  // Lowest-index requesting source wins; scan downward so it is assigned last.
  always_comb begin
    w_src_hit     = 1'b0;
    w_src_code    = '0;
    w_src_refill  = 1'b0;
    w_src_bad_we  = 1'b0;
    w_src_badaddr = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (bus.exc_req[i]) begin
        w_src_hit     = 1'b1;
        w_src_code    = bus.exc_code_in[5*i +: 5];
        w_src_refill  = bus.exc_refill[i];
        w_src_bad_we  = bus.exc_bad_we[i];
        w_src_badaddr = bus.exc_badaddr[32*i +: 32];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_cnt         = r_cnt;
    w_nxt_flush       = r_flush;
    w_nxt_cp0_wr_exp  = 1'b0;
    w_nxt_clear_exl   = 1'b0;
    w_nxt_badvaddr_we = 1'b0;
    w_nxt_exc_code    = r_exc_code;
    w_nxt_epc         = r_epc;
    w_nxt_badvaddr    = r_badvaddr;
    w_nxt_new_pc      = r_new_pc;
    case (r_state)
      ST_IDLE: begin
        if (w_take) begin
          w_nxt_state = ST_FLUSH;
          w_nxt_cnt   = CNT_W'(1);
          w_nxt_flush = 1'b1;
          if (w_int) begin
            w_nxt_exc_code   = 5'd0;
            w_nxt_epc        = bus.epc_in;
            w_nxt_cp0_wr_exp = 1'b1;
            w_nxt_new_pc     = w_base + GEN_OFS;
          end else if (w_src_hit) begin
            w_nxt_exc_code    = w_src_code;
            w_nxt_epc         = bus.epc_in;
            w_nxt_cp0_wr_exp  = 1'b1;
            w_nxt_badvaddr_we = w_src_bad_we;
            if (w_src_bad_we) w_nxt_badvaddr = w_src_badaddr;
            // TLB refill uses the base vector only outside exception level.
            w_nxt_new_pc = (w_src_refill & ~bus.sr_exl) ? w_base : w_base + GEN_OFS;
          end else begin
            w_nxt_clear_exl = 1'b1;
            w_nxt_new_pc    = bus.eret_target;
          end
        end
      end
      ST_FLUSH: begin
        if (r_cnt != CNT_MAX) w_nxt_cnt = r_cnt + CNT_W'(1);
        if ((r_cnt >= CNT_MIN) && bus.fetch_ack) begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = '0;
          w_nxt_flush = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_flush       <= 1'b0;
      r_cp0_wr_exp  <= 1'b0;
      r_clear_exl   <= 1'b0;
      r_exc_code    <= '0;
      r_epc         <= '0;
      r_badvaddr    <= '0;
      r_badvaddr_we <= 1'b0;
      r_new_pc      <= '0;
    end else begin
      r_state       <= w_nxt_state;
      r_cnt         <= w_nxt_cnt;
      r_flush       <= w_nxt_flush;
      r_cp0_wr_exp  <= w_nxt_cp0_wr_exp;
      r_clear_exl   <= w_nxt_clear_exl;
      r_exc_code    <= w_nxt_exc_code;
      r_epc         <= w_nxt_epc;
      r_badvaddr    <= w_nxt_badvaddr;
      r_badvaddr_we <= w_nxt_badvaddr_we;
      r_new_pc      <= w_nxt_new_pc;
    end
  end

`ifdef EXC_ARB_PERF_CNT_EN
  logic [31:0] r_exc_count;

  // Counts taken exceptions/interrupts; ERET never pulses cp0_wr_exp.
  always_ff @(posedge clk) begin
    if (reset)             r_exc_count <= '0;
    else if (r_cp0_wr_exp) r_exc_count <= r_exc_count + 32'd1;
  end

  assign exc_count = r_exc_count;
`endif

  assign bus.cur_exc     = w_take;
  assign bus.flush       = r_flush;
  assign bus.flush_vec   = {FLUSH_STAGES{r_flush}};
  assign bus.cp0_wr_exp  = r_cp0_wr_exp;
  assign bus.clear_exl   = r_clear_exl;
  assign bus.exc_code    = r_exc_code;
  assign bus.epc         = r_epc;
  assign bus.badvaddr    = r_badvaddr;
  assign bus.badvaddr_we = r_badvaddr_we;
  assign bus.new_pc      = r_new_pc;

endmodule

// File: doc/exc_arbiter.md
# exc_arbiter

Parametrised exception arbiter and pipeline-flush controller for the MIPS core. It prioritises a configurable number of synchronous exception sources against interrupts and ERET, and computes the vector and CP0 update fields. It then holds the pipeline flush asserted until the fetch side acknowledges the redirect. It sits between the memory stage (which collects per-stage exception flags) and CP0/PC-select, and generalises the fixed-priority exception unit to N sources with a flush-hold state machine.

## Interface
- `NUM_SRC`, default 12: number of synchronous exception sources; index 0 has the highest priority.
- `INT_W`, default 8: interrupt pending width.
- `FLUSH_STAGES`, default 4: width of `flush_vec`.
- `MIN_FLUSH`, default 1: minimum number of cycles `flush` stays high (1..15).
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `exc_req` in NUM_SRC: per-source exception request.
- `exc_code_in` in NUM_SRC*5: ExcCode per source; slice i is bits [5i+4:5i].
- `exc_refill` in NUM_SRC: source uses the TLB-refill vector.
- `exc_bad_we` in NUM_SRC: source writes BadVAddr.
- `exc_badaddr` in NUM_SRC*32: BadVAddr value per source.
- `epc_in` in 32: EPC of the faulting instruction (delay slot already resolved).
- `eret` in 1: ERET in the commit stage.
- `eret_target` in 32: CP0 EPC value.
- `allow_int` in 1: IE=1, EXL=0, ERL=0.
- `int_pending` in INT_W: IP & IM.
- `sr_bev` in 1: Status.BEV.
- `sr_exl` in 1: Status.EXL.
- `ebase` in 32: EBase.
- `fetch_ack` in 1: fetch side has accepted the redirect.
- `cur_exc` out 1: combinational; an event is being taken this cycle.
- `flush` out 1: pipeline flush.
- `flush_vec` out FLUSH_STAGES: per-stage flush, equal to `{FLUSH_STAGES{flush}}`.
- `cp0_wr_exp` out 1: one-cycle pulse that writes EPC, Cause and EXL.
- `clear_exl` out 1: one-cycle pulse on ERET.
- `exc_code` out 5: ExcCode of the last exception.
- `epc` out 32: EPC to write.
- `badvaddr` out 32: BadVAddr to write.
- `badvaddr_we` out 1: one-cycle pulse that writes BadVAddr.
- `new_pc` out 32: redirect target.

## Operation
- States: IDLE and FLUSH.
- In IDLE, one event is selected per cycle:
  1. Interrupt: `allow_int & |int_pending`. ExcCode is 0 and BadVAddr is not written.
  2. Otherwise, the lowest index i with `exc_req[i]` set. ExcCode is slice i; BadVAddr is written when `exc_bad_we[i]` is set.
  3. Otherwise, `eret`.
- `cur_exc` = (state==IDLE) & (interrupt | `|exc_req` | `eret`).
- Base address = `sr_bev ? 32'hBFC00200 : ebase`.
- Vector:
  - `new_pc = base` when `exc_refill[i] & !sr_exl`.
  - Otherwise `new_pc = base + 32'h180`, a 32-bit wrapping add.
  - For ERET, `new_pc = eret_target`.
- On an exception, register `epc <= epc_in` and `exc_code`, and pulse `cp0_wr_exp`.
- On ERET, pulse `clear_exl`. `cp0_wr_exp`, `exc_code` and `epc` are unchanged.
- Taking any event sets `flush` and moves the state to FLUSH.
- In FLUSH:
  - All requests, including interrupts, are ignored and `cur_exc` = 0.
  - The hold counter increments, saturating at 15.
  - Exit to IDLE and clear `flush` when counter ≥ MIN_FLUSH and `fetch_ack` = 1.
- `exc_code`, `epc`, `badvaddr` and `new_pc` hold their values until the next event.
- Reset, including mid-FLUSH: state IDLE, counter 0, every output register 0.

## Timing
- An event is sampled at edge N; all registered outputs are valid from cycle N+1.
- `cp0_wr_exp`, `clear_exl` and `badvaddr_we` are high for exactly cycle N+1.
- The hold counter is 1 in cycle N+1.
- `flush` is high for at least MIN_FLUSH cycles. It falls in the cycle after the first FLUSH cycle in which both counter ≥ MIN_FLUSH and `fetch_ack` = 1.
- `fetch_ack` high in cycle N+1 with MIN_FLUSH=1 gives a one-cycle flush.
- A request present in the exit cycle is ignored. It is taken in the first IDLE cycle if it is still asserted.
- Back-to-back events are separated by at least MIN_FLUSH+1 cycles.
- Simultaneous interrupt, source and ERET: the interrupt wins and the others are dropped. The pipeline replays them.

## Configuration
- Macro `EXC_ARB_PERF_CNT_EN`.
- Defined:
  - Adds output `exc_count` (32 bits), reset to 0.
  - It increments on every `cp0_wr_exp` pulse, excluding ERET, and wraps at 2^32.
- Undefined: the port and the counter are absent.

## Test plan
- Source 3 only, `exc_code_in[3]` = 5'h04, `exc_bad_we[3]` = 1, badaddr 0x00400001, `epc_in` 0x80001000, BEV=0, ebase 0x80000000 -> next cycle `new_pc` 0x80000180, `exc_code` 4, `badvaddr` 0x00400001, `badvaddr_we` = `cp0_wr_exp` = 1 for one cycle.
- Sources 2 and 5 together with the interrupt (`allow_int` = 1, `int_pending` 8'h04) -> `exc_code` 0, `badvaddr_we` 0. Then sources 2 and 5 without the interrupt -> source 2 wins.
- Refill source with EXL=0, BEV=1 -> `new_pc` 0xBFC00200. The same source with EXL=1 -> 0xBFC00380.
- MIN_FLUSH=3, `fetch_ack` tied to 1 -> `flush` high exactly 3 cycles. `fetch_ack` held low for 10 cycles -> `flush` stays high and a new `exc_req` is ignored.
- ERET with `eret_target` 0x80002000 -> `clear_exl` pulses once, `new_pc` 0x80002000, `cp0_wr_exp` stays 0. Reset asserted mid-FLUSH -> all outputs 0 and state IDLE.
